// File: rtl/signed_div_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : signed_div_scheduler_if
//  Description : Request/result bundle for signed_div_scheduler. Two request
//                channels (valid/ready with signed dividend and divisor) and
//                one result channel (valid/ready with id, quotient, dbz),
//                plus the busy status.
//                  slave  : the scheduler (consumes requests, emits results)
//                  master : the requesters / result consumer
//  Revision    : 1.0  initial release
// ============================================================================
interface signed_div_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
);
    logic              i_req0_valid;
    logic [DATA_W-1:0] i_req0_dividend;
    logic [DATA_W-1:0] i_req0_divisor;
    logic              o_req0_ready;
    logic              i_req1_valid;
    logic [DATA_W-1:0] i_req1_dividend;
    logic [DATA_W-1:0] i_req1_divisor;
    logic              o_req1_ready;
    logic              o_res_valid;
    logic              i_res_ready;
    logic              o_res_id;
    logic [DATA_W-1:0] o_res_quotient;
    logic              o_res_dbz;
    logic              o_busy;

    modport slave (
        input  i_req0_valid, i_req0_dividend, i_req0_divisor,
        input  i_req1_valid, i_req1_dividend, i_req1_divisor,
        input  i_res_ready,
        output o_req0_ready, o_req1_ready,
        output o_res_valid, o_res_id, o_res_quotient, o_res_dbz, o_busy
    );

    modport master (
        output i_req0_valid, i_req0_dividend, i_req0_divisor,
        output i_req1_valid, i_req1_dividend, i_req1_divisor,
        output i_res_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_res_valid, o_res_id, o_res_quotient, o_res_dbz, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/signed_div_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : signed_div_scheduler
//  Description : Two-channel round-robin front end for a single sequential
//                signed fixed-point divider, Q(DATA_W-FRAC_W).FRAC_W format.
//                Restoring division, one quotient bit per clock, MSB first,
//                followed by sign application and saturation.
//  Ports       : i_clk   - clock, rising edge
//                i_reset - synchronous active-high reset
//                bus     - signed_div_scheduler_if.slave (requests, result,
//                          busy)
//  Revision    : 1.0  initial release
// ============================================================================
module signed_div_scheduler #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    signed_div_scheduler_if.slave  bus
);
    localparam int NW    = DATA_W + FRAC_W;   // numerator / raw quotient width
    localparam int CNT_W = $clog2(NW);

    localparam logic [DATA_W-1:0] c_MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [NW-1:0]     c_POS_MAG = {{(FRAC_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [NW-1:0]     c_NEG_MAG = {{FRAC_W{1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIXUP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state_q,   w_state_d;
    logic              r_ptr_q,     w_ptr_d;      // channel holding priority
    logic              r_id_q,      w_id_d;
    logic              r_dvd_neg_q, w_dvd_neg_d;
    logic              r_quo_neg_q, w_quo_neg_d;
    logic              r_dbz_q,     w_dbz_d;
    logic [DATA_W-1:0] r_div_q,     w_div_d;      // |divisor|
    logic [DATA_W-1:0] r_rem_q,     w_rem_d;      // partial remainder
    logic [NW-1:0]     r_nq_q,      w_nq_d;       // numerator in, quotient out
    logic [CNT_W-1:0]  r_cnt_q,     w_cnt_d;
    logic              r_res_id_q,  w_res_id_d;
    logic [DATA_W-1:0] r_res_quo_q, w_res_quo_d;
    logic              r_res_dbz_q, w_res_dbz_d;

    logic              w_gnt0, w_gnt1, w_accept, w_sel;
    logic [DATA_W-1:0] w_dvd, w_dvs, w_dvd_mag, w_dvs_mag;
    logic [DATA_W:0]   w_rem_shift, w_rem_sub;
    logic              w_qbit;
    logic [DATA_W-1:0] w_fix_quo, w_nq_lo, w_nq_neg;

    // Grant: only in IDLE and never under reset; with both valid the
    // pointer decides, otherwise the lone requester wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state_q == S_IDLE && !i_reset) begin
            if (bus.i_req0_valid && bus.i_req1_valid) begin
                w_gnt0 = ~r_ptr_q;
                w_gnt1 = r_ptr_q;
            end else begin
                w_gnt0 = bus.i_req0_valid;
                w_gnt1 = bus.i_req1_valid;
            end
        end
    end

    assign w_accept  = w_gnt0 | w_gnt1;
    assign w_sel     = w_gnt1;
    assign w_dvd     = w_sel ? bus.i_req1_dividend : bus.i_req0_dividend;
    assign w_dvs     = w_sel ? bus.i_req1_divisor  : bus.i_req0_divisor;
    // Unsigned magnitudes; the most negative value maps to 2^(DATA_W-1).
    assign w_dvd_mag = w_dvd[DATA_W-1] ? ({DATA_W{1'b0}} - w_dvd) : w_dvd;
    assign w_dvs_mag = w_dvs[DATA_W-1] ? ({DATA_W{1'b0}} - w_dvs) : w_dvs;

    // One restoring step: the remainder stays below the divisor, so the
    // shifted value fits in DATA_W+1 bits and the result back in DATA_W.
    assign w_rem_shift = {r_rem_q, r_nq_q[NW-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_div_q};
    assign w_qbit      = (w_rem_shift >= {1'b0, r_div_q});

    assign w_nq_lo  = r_nq_q[DATA_W-1:0];
    assign w_nq_neg = {DATA_W{1'b0}} - w_nq_lo;

    always_comb begin
        w_fix_quo = w_nq_lo;
        if (r_dbz_q) begin
            w_fix_quo = r_dvd_neg_q ? c_MIN_NEG : c_MAX_POS;
        end else if (r_quo_neg_q && (r_nq_q != '0)) begin
            w_fix_quo = (r_nq_q > c_NEG_MAG) ? c_MIN_NEG : w_nq_neg;
        end else begin
            w_fix_quo = (r_nq_q > c_POS_MAG) ? c_MAX_POS : w_nq_lo;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_ptr_d     = r_ptr_q;
        w_id_d      = r_id_q;
        w_dvd_neg_d = r_dvd_neg_q;
        w_quo_neg_d = r_quo_neg_q;
        w_dbz_d     = r_dbz_q;
        w_div_d     = r_div_q;
        w_rem_d     = r_rem_q;
        w_nq_d      = r_nq_q;
        w_cnt_d     = r_cnt_q;
        w_res_id_d  = r_res_id_q;
        w_res_quo_d = r_res_quo_q;
        w_res_dbz_d = r_res_dbz_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_id_d      = w_sel;
                    w_ptr_d     = ~w_sel;
                    w_dvd_neg_d = w_dvd[DATA_W-1];
                    w_quo_neg_d = w_dvd[DATA_W-1] ^ w_dvs[DATA_W-1];
                    w_dbz_d     = (w_dvs == '0);
                    w_div_d     = w_dvs_mag;
                    w_rem_d     = '0;
                    w_nq_d      = {w_dvd_mag, {FRAC_W{1'b0}}};
                    w_cnt_d     = '0;
                    // A zero divisor skips the iterations but still uses the
                    // FIXUP slot, so its result appears one edge after accept.
                    w_state_d   = (w_dvs == '0) ? S_FIXUP : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                w_rem_d = w_qbit ? w_rem_sub[DATA_W-1:0] : w_rem_shift[DATA_W-1:0];
                w_nq_d  = {r_nq_q[NW-2:0], w_qbit};
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == CNT_W'(NW-1)) begin
                    w_state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                w_res_id_d  = r_id_q;
                w_res_dbz_d = r_dbz_q;
                w_res_quo_d = w_fix_quo;
                w_state_d   = S_DONE;
            end
            S_DONE: begin
                if (bus.i_res_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q   <= S_IDLE;
            r_ptr_q     <= 1'b0;
            r_id_q      <= 1'b0;
            r_dvd_neg_q <= 1'b0;
            r_quo_neg_q <= 1'b0;
            r_dbz_q     <= 1'b0;
            r_div_q     <= '0;
            r_rem_q     <= '0;
            r_nq_q      <= '0;
            r_cnt_q     <= '0;
            r_res_id_q  <= 1'b0;
            r_res_quo_q <= '0;
            r_res_dbz_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_ptr_q     <= w_ptr_d;
            r_id_q      <= w_id_d;
            r_dvd_neg_q <= w_dvd_neg_d;
            r_quo_neg_q <= w_quo_neg_d;
            r_dbz_q     <= w_dbz_d;
            r_div_q     <= w_div_d;
            r_rem_q     <= w_rem_d;
            r_nq_q      <= w_nq_d;
            r_cnt_q     <= w_cnt_d;
            r_res_id_q  <= w_res_id_d;
            r_res_quo_q <= w_res_quo_d;
            r_res_dbz_q <= w_res_dbz_d;
        end
    end

    assign bus.o_req0_ready   = w_gnt0;
    assign bus.o_req1_ready   = w_gnt1;
    assign bus.o_res_valid    = (r_state_q == S_DONE);
    assign bus.o_res_id       = r_res_id_q;
    assign bus.o_res_quotient = r_res_quo_q;
    assign bus.o_res_dbz      = r_res_dbz_q;
    assign bus.o_busy         = (r_state_q != S_IDLE);
endmodule
`default_nettype wire
